// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: synchronised edge capture, pending/mask/IE
// gating and the request/acknowledge/return handshake with the control unit.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | waiting for IE=1 and a pending, unmasked source
//   S_REQ     | INTR high, winner and VECTOR frozen until ack or CLI
//   S_SERVICE | ACTIVE high, handler running, no nesting until RETI
module interrupt_controller #(
    parameter int               NUM_SRC  = 4,
    parameter int               VEC_W    = 8,
    parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'(8'hF0)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    input  logic               MASK_WE,
    input  logic [NUM_SRC-1:0] MASK_DIN,
    input  logic               SEI,
    input  logic               CLI,
    input  logic               INT_ACK,
    input  logic               RETI,
    output logic               INTR,
    output logic [VEC_W-1:0]   VECTOR,
    output logic               ACTIVE,
    output logic               IE,
    output logic [NUM_SRC-1:0] PENDING
);

    localparam int WIN_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] sync1_q, sync1_d;
    logic [NUM_SRC-1:0] sync2_q, sync2_d;
    logic [NUM_SRC-1:0] dly_q, dly_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               ie_q, ie_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [VEC_W-1:0]   vector_q, vector_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] clr;
    logic [WIN_W-1:0]   win_c;
    logic               ack_take;

    always_comb begin
        sync1_d  = IRQ_IN;
        sync2_d  = sync1_q;
        dly_d    = sync2_q;
        rise     = sync2_q & ~dly_q;
        elig     = pending_q & mask_q;
        mask_d   = MASK_WE ? MASK_DIN : mask_q;

        // Scan high to low so the lowest eligible index is the one left standing.
        win_c = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) win_c = WIN_W'(i);
        end

        state_d  = state_q;
        win_d    = win_q;
        vector_d = vector_q;
        ack_take = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ie_q && (elig != '0)) begin
                    state_d  = S_REQ;
                    win_d    = win_c;
                    vector_d = VEC_BASE + VEC_W'(win_c);
                end
            end
            S_REQ: begin
                if (INT_ACK) begin
                    state_d  = S_SERVICE;
                    ack_take = 1'b1;
                end else if (CLI) begin
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (RETI) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh edge in the acknowledge cycle re-sets the bit being cleared.
        clr       = ack_take ? (NUM_SRC'(1) << win_q) : '0;
        pending_d = (pending_q & ~clr) | rise;

        ie_d = ie_q;
        if (CLI)      ie_d = 1'b0;
        if (SEI)      ie_d = 1'b1;
        if (RETI)     ie_d = 1'b1;
        if (ack_take) ie_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            dly_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            ie_q      <= 1'b0;
            win_q     <= '0;
            vector_q  <= VEC_BASE;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            dly_q     <= dly_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            ie_q      <= ie_d;
            win_q     <= win_d;
            vector_q  <= vector_d;
        end
    end

    assign INTR    = (state_q == S_REQ);
    assign ACTIVE  = (state_q == S_SERVICE);
    assign IE      = ie_q;
    assign VECTOR  = vector_q;
    assign PENDING = pending_q;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Multi-source interrupt controller for the MCU core.
- Synchronizes and edge-detects external interrupt lines, latches pending requests, and applies a per-source mask and a global interrupt-enable flag.
- Arbitrates by fixed priority and runs the request/acknowledge/return handshake with the control-unit FSM.
- Supplies the branch vector of the winning source. It owns the global enable flag, so the control unit drives only SEI/CLI/RETI strobes.

Parameters:
NUM_SRC, 4, number of interrupt sources (1..8)
VEC_W, 8, width of vector output (program-counter low bits)
VEC_BASE, 8'h F0, vector of source 0; source i vectors to VEC_BASE + i

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
IRQ_IN  in  NUM_SRC  raw interrupt lines, asynchronous, rising-edge triggered
MASK_WE  in  1  write strobe for mask register
MASK_DIN  in  NUM_SRC  new mask value (1 = enabled)
SEI  in  1  set global enable strobe
CLI  in  1  clear global enable strobe
INT_ACK  in  1  control unit accepts the interrupt (one-cycle strobe)
RETI  in  1  return-from-interrupt strobe (one cycle)
INTR  out  1  interrupt request to control unit
VECTOR  out  VEC_W  vector of the latched winner; valid while INTR or ACTIVE is high
ACTIVE  out  1  an interrupt is being serviced
IE  out  1  global interrupt-enable flag
PENDING  out  NUM_SRC  pending register, for debug/status reads

Behaviour:
- Reset (RST_N low, asynchronous):
  - INTR=0, ACTIVE=0, IE=0, PENDING=0, mask=0, VECTOR=VEC_BASE.
  - Synchronizer and edge-detect flops cleared; state=IDLE.
- Synchronizer and edge detect:
  - Each IRQ_IN bit passes through a 2-flop synchronizer, then a delay flop for edge detect.
  - A 0->1 edge sets PENDING[i]. A pulse must be high for at least 2 CLK periods to be caught.
  - Latency: if IRQ_IN rises before edge k, PENDING[i] is high after edge k+2.
- Mask register: loaded from MASK_DIN at the edge where MASK_WE=1. Masking never clears PENDING.
- Global enable flag (IE):
  - SEI sets it; CLI clears it. SEI and CLI in the same cycle: SEI wins.
  - Cleared automatically on INT_ACK and set automatically on RETI.
  - RETI and CLI in the same cycle: IE=1.
- Eligible set: PENDING & mask. Winner is the lowest-indexed eligible bit.
- FSM:
  - IDLE:
    - If IE=1 and eligible set nonzero, latch winner index and go to REQ. INTR=1 from the next cycle.
    - VECTOR = VEC_BASE + winner, registered at the same edge.
  - REQ (INTR=1):
    - Winner and VECTOR are frozen; later higher-priority arrivals or mask changes do not alter them.
    - INT_ACK=1: clear PENDING[winner], clear IE, go to SERVICE (INTR=0, ACTIVE=1 next cycle).
    - CLI=1 without INT_ACK: withdraw, go to IDLE, INTR=0 next cycle, PENDING retained.
    - INT_ACK and CLI in the same cycle: ACK wins.
  - SERVICE (ACTIVE=1):
    - No new request; INTR=0 even if SEI makes IE=1 (no nesting).
    - RETI=1: go to IDLE, IE=1, ACTIVE=0 next cycle.
    - Earliest next INTR is 1 cycle after return to IDLE.
- Simultaneous set and clear of one PENDING bit: a new edge on source i in the same cycle as INT_ACK clears PENDING[i] leaves it set, so the second event is not lost.
- INT_ACK in IDLE or SERVICE, and RETI outside SERVICE, are ignored (no state change; RETI still sets IE).
- RST_N asserted mid-operation aborts any REQ/SERVICE immediately. Outputs take their reset values asynchronously.
- Pending width is NUM_SRC bits; winner index is clog2(NUM_SRC) bits. VECTOR addition wraps modulo 2^VEC_W.

Test Plan:
1. Reset, mask=4'b1111, SEI. Pulse IRQ_IN[2] for 2 cycles -> PENDING=4'b0100 after 3 edges, INTR=1 next cycle, VECTOR=8'hF2. INT_ACK -> PENDING=0, IE=0, ACTIVE=1. RETI -> ACTIVE=0, IE=1.
2. Pulse IRQ_IN[3] and IRQ_IN[1] together, IE=1 -> VECTOR=8'hF1 served first. After RETI, INTR reasserts with VECTOR=8'hF3.
3. Pending source 0 with mask=4'b1110 -> no INTR. Write mask=4'b1111 -> INTR asserts, VECTOR=8'hF0.
4. In REQ (VECTOR=8'hF2), assert CLI -> INTR drops next cycle, PENDING[2] still 1. SEI -> INTR returns, VECTOR=8'hF2.
5. Edge on IRQ_IN[0] arrives during SERVICE -> no INTR until RETI. A second edge on source 0 in the same cycle as its INT_ACK -> PENDING[0] remains 1.
6. Drop RST_N during SERVICE -> ACTIVE, IE, INTR, PENDING = 0 immediately, without waiting for a clock edge. Release RST_N -> IDLE, no spurious INTR.
